// File: rtl/adc_pipe_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// The master side drives operands and consumes results; the slave side is the unit itself.
interface adc_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             Ov;
    logic             Zero;

    modport master (
        output in_valid, A, B, C0, sub, out_ready,
        input  in_ready, out_valid, S, Co, Ov, Zero
    );

    modport slave (
        input  in_valid, A, B, C0, sub, out_ready,
        output in_ready, out_valid, S, Co, Ov, Zero
    );
endinterface

// File: rtl/adc_pipe.sv
// Pipelined WIDTH-bit add/subtract: one CW-bit carry-chained chunk per stage,
// with borrow-in, overflow/zero flags and a valid/ready handshake with backpressure.
module adc_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    adc_pipe_if.slave   bus
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] be_q  [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             vld_q [STAGES];

    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] be_d  [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_d   [STAGES];
    logic             vld_d [STAGES];

    logic [WIDTH-1:0] a_src_s   [STAGES];
    logic [WIDTH-1:0] be_src_s  [STAGES];
    logic [WIDTH-1:0] s_src_s   [STAGES];
    logic             cin_src_s [STAGES];
    logic             vld_src_s [STAGES];
    logic [CW:0]      chunk_s   [STAGES];

    logic co_q, ov_q, zero_q;
    logic co_d, ov_d, zero_d;
    logic adv_s;

    // One global advance: everything moves unless a finished result is being held.
    assign adv_s         = ~vld_q[LAST] | bus.out_ready;
    assign bus.in_ready  = adv_s;
    assign bus.out_valid = vld_q[LAST];
    assign bus.S         = s_q[LAST];
    assign bus.Co        = co_q;
    assign bus.Ov        = ov_q;
    assign bus.Zero      = zero_q;

    // Stage inputs: stage 0 takes the (conditionally inverted) operands, later stages the previous stage.
    always_comb begin
        a_src_s[0]   = bus.A;
        be_src_s[0]  = bus.sub ? ~bus.B : bus.B;
        cin_src_s[0] = bus.sub ? ~bus.C0 : bus.C0;
        s_src_s[0]   = '0;
        vld_src_s[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src_s[k]   = a_q[k-1];
            be_src_s[k]  = be_q[k-1];
            cin_src_s[k] = c_q[k-1];
            s_src_s[k]   = s_q[k-1];
            vld_src_s[k] = vld_q[k-1];
        end
    end

    // Per-stage chunk add and next-state for every pipeline register, plus final-stage flags.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            chunk_s[k] = {1'b0, a_src_s[k][k*CW +: CW]}
                       + {1'b0, be_src_s[k][k*CW +: CW]}
                       + {{CW{1'b0}}, cin_src_s[k]};
            s_d[k]              = s_src_s[k];
            s_d[k][k*CW +: CW]  = chunk_s[k][CW-1:0];
            c_d[k]              = chunk_s[k][CW];
            a_d[k]              = a_src_s[k];
            be_d[k]             = be_src_s[k];
            vld_d[k]            = vld_src_s[k];
        end
        co_d   = ~c_d[LAST];
        ov_d   = (a_src_s[LAST][WIDTH-1] == be_src_s[LAST][WIDTH-1])
              && (s_d[LAST][WIDTH-1] != a_src_s[LAST][WIDTH-1]);
        zero_d = (s_d[LAST] == '0);
    end

    // Pipeline registers: cleared asynchronously, otherwise advance together or all hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                be_q[k]  <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                vld_q[k] <= 1'b0;
            end
            co_q   <= 1'b0;
            ov_q   <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                be_q[k]  <= be_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                vld_q[k] <= vld_d[k];
            end
            co_q   <= co_d;
            ov_q   <= ov_d;
            zero_q <= zero_d;
        end
    end
endmodule

// File: tb/tb_adc_pipe.sv
// Bench for adc_pipe: three configurations (32/4, 64/8, 8/1) share one stimulus stream,
// each checked every cycle against an arithmetic reference model and an in-order queue.
module tb_adc_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        c0;
    logic        sub;
    logic [63:0] a_drv;
    logic [63:0] b_drv;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: true integer A+B+C0 or A-B-C0; returns {S[63:0], Co, Ov, Zero}.
    function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic s);
        logic [63:0] mask, res;
        logic [65:0] ur, sa, sb, sr;
        logic        co, ov;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a    = a & mask;
        b    = b & mask;
        ur   = s ? ({2'b00, a} - {2'b00, b} - {65'd0, c}) : ({2'b00, a} + {2'b00, b} + {65'd0, c});
        res  = ur[63:0] & mask;
        co   = s ? ur[65] : ~ur[w];
        sa   = {2'b00, a};
        sb   = {2'b00, b};
        if (a[w-1]) sa = sa - (66'd1 << w);
        if (b[w-1]) sb = sb - (66'd1 << w);
        sr   = s ? (sa - sb - {65'd0, c}) : (sa + sb + {65'd0, c});
        ov   = ((sr + (66'd1 << (w - 1))) >= (66'd1 << w));
        return {res, co, ov, (res == 64'd0)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W  = (g == 0) ? 32 : ((g == 1) ? 64 : 8);
        localparam int ST = (g == 0) ? 4  : ((g == 1) ? 8  : 1);

        adc_pipe_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.A         = a_drv[W-1:0];
        assign bus.B         = b_drv[W-1:0];
        assign bus.C0        = c0;
        assign bus.sub       = sub;
        assign bus.out_ready = out_ready;

        adc_pipe #(.WIDTH(W), .STAGES(ST)) dut (.clk(clk), .rst(rst), .bus(bus));

        logic [66:0] exp_q [$];
        int          acc_q [$];
        int          stl_q [$];
        int          stall_cnt = 0;
        bit          seen      = 1'b0;

        always @(negedge clk) begin : cmp
            logic [63:0] s_act;
            logic [66:0] got;
            s_act        = '0;
            s_act[W-1:0] = bus.S;
            got          = {s_act, bus.Co, bus.Ov, bus.Zero};
            if (!rst) begin
                checks++;
                if (bus.out_valid !== 1'b0 || got !== 67'd0) begin
                    errors++;
                    $display("FAIL cfg%0d reset_state valid=%b got=%h want valid=0 all zero", g, bus.out_valid, got);
                end
                exp_q.delete();
                acc_q.delete();
                stl_q.delete();
                seen = 1'b0;
            end else begin
                checks++;
                if (bus.in_ready !== (!bus.out_valid || out_ready)) begin
                    errors++;
                    $display("FAIL cfg%0d in_ready got=%b want=%b", g, bus.in_ready, (!bus.out_valid || out_ready));
                end
                if (bus.out_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL cfg%0d spurious_result got=%h want no valid output", g, got);
                    end else begin
                        if (got !== exp_q[0]) begin
                            errors++;
                            $display("FAIL cfg%0d result got=%h want=%h", g, got, exp_q[0]);
                        end
                        if (!seen) begin
                            seen = 1'b1;
                            if (stl_q[0] == stall_cnt) begin
                                checks++;
                                if (cyc - acc_q[0] != ST) begin
                                    errors++;
                                    $display("FAIL cfg%0d latency got=%0d want=%0d", g, cyc - acc_q[0], ST);
                                end
                            end
                        end
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                            void'(stl_q.pop_front());
                            seen = 1'b0;
                        end
                    end
                    if (!out_ready) stall_cnt++;
                end
                if (in_valid && bus.in_ready) begin
                    exp_q.push_back(model(W, a_drv, b_drv, c0, sub));
                    acc_q.push_back(cyc);
                    stl_q.push_back(stall_cnt);
                end
            end
        end
    end

    task automatic pin(input string name, input logic [66:0] got, input logic [66:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL pin_%s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
        bit r;
        int n;
        a_drv    = a;
        b_drv    = b;
        c0       = c;
        sub      = s;
        in_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            r = cfg[0].bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 100);
        in_valid = 1'b0;
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 for %0d cycles want accept", n);
        end
    endtask

    task automatic direct(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic s, input logic [31:0] ws,
                          input logic wco, input logic wov, input logic wz);
        send(a, b, c, s);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cfg[0].bus.out_valid !== 1'b1 || cfg[0].bus.S !== ws || cfg[0].bus.Co !== wco
            || cfg[0].bus.Ov !== wov || cfg[0].bus.Zero !== wz) begin
            errors++;
            $display("FAIL direct_%s got v=%b S=%h Co=%b Ov=%b Z=%b want v=1 S=%h Co=%b Ov=%b Z=%b",
                     name, cfg[0].bus.out_valid, cfg[0].bus.S, cfg[0].bus.Co, cfg[0].bus.Ov,
                     cfg[0].bus.Zero, ws, wco, wov, wz);
        end
    endtask

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog got no finish want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c0        = 1'b0;
        sub       = 1'b0;
        a_drv     = 64'd0;
        b_drv     = 64'd0;

        pin("wrap",   model(32, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0), {64'h0, 1'b0, 1'b0, 1'b1});
        pin("borrow", model(32, 64'd5, 64'd7, 1'b0, 1'b1),         {64'hFFFF_FFFE, 1'b1, 1'b0, 1'b0});
        pin("subov",  model(32, 64'h8000_0000, 64'd1, 1'b0, 1'b1), {64'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
        pin("ripple", model(32, 64'h00FF_FFFF, 64'd1, 1'b1, 1'b0), {64'h0100_0001, 1'b1, 1'b0, 1'b0});
        pin("addov8", model(8, 64'h7F, 64'h00, 1'b1, 1'b0),        {64'h80, 1'b1, 1'b1, 1'b0});
        pin("sub64",  model(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1),
            {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        direct("wrap",   64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        direct("borrow", 64'd5,         64'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        direct("subov",  64'h8000_0000, 64'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        direct("ripple", 64'h00FF_FFFF, 64'd1, 1'b1, 1'b0, 32'h0100_0001, 1'b1, 1'b0, 1'b0);

        // Eight back-to-back beats with the consumer stalling for three cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(64'h0000_1111_0000_1111 * (i + 1), 64'h0000_00FF_0000_F0F0 + i, i[0], i[1]);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;

        // Reset with three beats in flight; nothing stale may emerge afterwards.
        send(64'd10, 64'd20, 1'b0, 1'b0);
        send(64'd30, 64'd40, 1'b1, 1'b0);
        send(64'd50, 64'd60, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        checks++;
        if (cfg[0].bus.out_valid !== 1'b0 || cfg[0].bus.S !== 32'd0 || cfg[0].bus.Co !== 1'b0
            || cfg[0].bus.Ov !== 1'b0 || cfg[0].bus.Zero !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset got v=%b S=%h want v=0 S=0 flags 0",
                     cfg[0].bus.out_valid, cfg[0].bus.S);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        repeat (1150) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            a_drv     = {$urandom, $urandom};
            b_drv     = {$urandom, $urandom};
            c0        = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        checks++;
        if (cfg[0].exp_q.size() != 0 || cfg[1].exp_q.size() != 0 || cfg[2].exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d/%0d/%0d want 0/0/0",
                     cfg[0].exp_q.size(), cfg[1].exp_q.size(), cfg[2].exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
